sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DW, 8, RAM data width.
- WORDS, 4, RAM depth.
- NREQ, 3, number of requesters (>=1).
- AW, max(1,$clog2(WORDS)), address width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning; clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester access request.
- lock  in  NREQ  hold grant across cycles while asserted by the current owner.
- we  in  NREQ  1 = write, 0 = read, per requester.
- addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data, same packing.
- gnt  out  NREQ  one-hot grant, combinational.
- rvalid  out  NREQ  read data valid, one-hot.
- rdata  out  DW  read data, shared by all requesters.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_qout  in  DW  RAM read data, valid 1 cycle after a read access.
REQ-003 The clock SHALL be a single clock and the reset SHALL be asynchronous and active-low, named clk and rst_n.

Function
REQ-004 gnt SHALL be one-hot or zero; gnt[i] SHALL only be high when req[i] is high.
REQ-005 A transfer for requester i SHALL occur in any cycle with req[i] & gnt[i]; there are no wait states.
REQ-006 Arbitration SHALL be round-robin: the search starts at pointer ptr and wraps NREQ-1 -> 0; the first requester found with req high is granted.
REQ-007 After a transfer by requester i with lock[i] low, ptr SHALL become (i+1) mod NREQ on the next edge.
REQ-008 After a transfer by requester i with lock[i] high, the block SHALL enter LOCKED(owner=i) and ptr SHALL stay unchanged.
REQ-009 In LOCKED(owner=i), gnt SHALL equal req[i] at bit i and zero elsewhere; all other requesters SHALL be blocked.
REQ-010 LOCKED SHALL exit to IDLE on the edge following a cycle where owner i has req[i] low or lock[i] low; ptr SHALL then become (i+1) mod NREQ.
REQ-011 With no granted requester: ram_en, ram_we, ram_addr and ram_din SHALL all be 0.
REQ-012 With a granted requester: ram_en=1 and ram_we, ram_addr, ram_din SHALL equal that requester's we, addr and wdata slices, in the same cycle.
REQ-013 A read transfer by i in cycle N SHALL assert rvalid[i] for exactly cycle N+1, with rdata=ram_qout.
REQ-014 Write transfers SHALL NOT assert rvalid.
REQ-015 rdata SHALL be 0 when no rvalid bit is set.
REQ-016 Back-to-back reads by different requesters SHALL produce consecutive rvalid pulses in grant order.
REQ-017 NREQ=1: gnt SHALL equal req whenever out of reset, and lock has no effect.
REQ-018 Address bounds SHALL NOT be checked; addr >= WORDS is passed through unchanged.

Reset
REQ-019 While rst_n is low: gnt=0, rvalid=0, rdata=0, ram_en=0, ram_we=0, ptr=0, state=IDLE.
REQ-020 Reset asserted mid-LOCKED or mid-read SHALL drop the lock and the pending rvalid immediately; no rvalid appears after release.
REQ-021 After rst_n rises, requester 0 SHALL have first priority.

Verification
REQ-022 Use NREQ=3, DW=8, WORDS=4; the RAM model has 1-cycle read latency.
REQ-023 Scenario: req=3'b111, all reads, lock=0 for 6 cycles -> gnt sequence 001,010,100,001,010,100; rvalid follows each grant by 1 cycle.
REQ-024 Scenario: r1 writes 8'hA5 to addr 2, then r2 reads addr 2 -> ram_we=1, ram_addr=2 on the write; rvalid[2]=1 with rdata=8'hA5 on the cycle after the read.
REQ-025 Scenario: r0 holds req=1 and lock=1 for 4 cycles while r1 and r2 also request -> gnt=001 for 4 cycles; after r0 drops lock, gnt=010 next.
REQ-026 Scenario: only r2 requests, single cycle -> gnt=100; next cycle all three request -> gnt=001 (ptr wrapped to 0).
REQ-027 Scenario: rst_n pulsed low in the cycle after a read grant to r1 -> rvalid stays 0 throughout; after release with req=111 -> gnt=001.
REQ-028 Scenario: req=0 for 3 cycles -> ram_en=0, ram_addr=0, ram_din=0, rvalid=0.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NREQ requesters,
// with optional grant locking and a one-cycle registered read-valid return.
module sp_ram_arbiter #(
   parameter int DW    = 8,
   parameter int WORDS = 4,
   parameter int NREQ  = 3,
   parameter int AW    = ($clog2(WORDS) < 1) ? 1 : $clog2(WORDS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      lock,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [DW-1:0]        rdata,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_din,
   input  logic [DW-1:0]        ram_qout
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] rvalid_q, rvalid_d;

   logic [NREQ-1:0] grantVec;
   logic [PW-1:0]   grantIdx;
   logic            anyGnt;
   logic [NREQ-1:0] lockEff;
   int              rrIdx;

   // A single requester can never be starved, so locking is meaningless there.
   assign lockEff = (NREQ > 1) ? lock : '0;

   function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] i);
      return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      grantVec = '0;
      grantIdx = '0;
      anyGnt   = 1'b0;
      rrIdx    = 0;
      if (rst_n) begin
         if (state_q == LOCKED) begin
            grantIdx          = owner_q;
            anyGnt            = req[owner_q];
            grantVec[owner_q] = req[owner_q];
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               rrIdx = int'(ptr_q) + k;
               if (rrIdx >= NREQ) rrIdx = rrIdx - NREQ;
               if (!anyGnt && req[rrIdx]) begin
                  anyGnt          = 1'b1;
                  grantIdx        = PW'(rrIdx);
                  grantVec[rrIdx] = 1'b1;
               end
            end
         end
      end
   end

   assign gnt      = grantVec;
   assign ram_en   = anyGnt;
   assign ram_we   = anyGnt & we[grantIdx];
   assign ram_addr = anyGnt ? addr[grantIdx*AW +: AW] : '0;
   assign ram_din  = anyGnt ? wdata[grantIdx*DW +: DW] : '0;
   assign rvalid   = rvalid_q;
   assign rdata    = (|rvalid_q) ? ram_qout : '0;

   // Pointer only advances when a grant is released, so a locked owner keeps its place.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      rvalid_d = grantVec & ~we;
      if (state_q == LOCKED) begin
         if (!(req[owner_q] && lockEff[owner_q])) begin
            state_d = IDLE;
            ptr_d   = nextIdx(owner_q);
         end
      end else if (anyGnt) begin
         if (lockEff[grantIdx]) begin
            state_d = LOCKED;
            owner_d = grantIdx;
         end else begin
            ptr_d = nextIdx(grantIdx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         rvalid_q <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Table-driven bench for sp_ram_arbiter with a 1-cycle-latency RAM model;
// each row is one clock cycle of inputs and the outputs expected in that cycle.
module tb_sp_ram_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req, lock, we;
   logic [5:0]  addr;
   logic [23:0] wdata;
   logic [2:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        ram_en, ram_we;
   logic [1:0]  ram_addr;
   logic [7:0]  ram_din, ram_qout;
   logic [7:0]  mem [4];

   int nApplied = 0;
   int nMiss    = 0;

   sp_ram_arbiter #(.DW(8), .WORDS(4), .NREQ(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .lock     (lock),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_qout (ram_qout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: contents 8'h10+i after reset, read data one cycle after access.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mem[i] <= 8'h10 + 8'(i);
         ram_qout <= 8'h00;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_qout <= mem[ram_addr];
      end
   end

   typedef struct {
      logic        rstN;
      logic [2:0]  req, lock, we;
      logic [5:0]  addr;
      logic [23:0] wdata;
      logic [2:0]  eGnt, eRvalid;
      logic [7:0]  eRdata;
      logic        eEn, eWe;
      logic [1:0]  eAddr;
      logic [7:0]  eDin;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [2:0] q, logic [2:0] l, logic [2:0] w,
                               logic [5:0] a, logic [23:0] d, logic [2:0] g,
                               logic [2:0] rv, logic [7:0] rd, logic en, logic wr,
                               logic [1:0] ea, logic [7:0] ed);
      vec_t v;
      v.rstN = r; v.req = q; v.lock = l; v.we = w; v.addr = a; v.wdata = d;
      v.eGnt = g; v.eRvalid = rv; v.eRdata = rd; v.eEn = en; v.eWe = wr;
      v.eAddr = ea; v.eDin = ed;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst_n = v.rstN; req = v.req; lock = v.lock; we = v.we;
      addr = v.addr; wdata = v.wdata;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkRow(input int n, input vec_t v);
      checkOutput($sformatf("row%0d gnt", n),      32'(gnt),      32'(v.eGnt));
      checkOutput($sformatf("row%0d rvalid", n),   32'(rvalid),   32'(v.eRvalid));
      checkOutput($sformatf("row%0d rdata", n),    32'(rdata),    32'(v.eRdata));
      checkOutput($sformatf("row%0d ram_en", n),   32'(ram_en),   32'(v.eEn));
      checkOutput($sformatf("row%0d ram_we", n),   32'(ram_we),   32'(v.eWe));
      checkOutput($sformatf("row%0d ram_addr", n), 32'(ram_addr), 32'(v.eAddr));
      checkOutput($sformatf("row%0d ram_din", n),  32'(ram_din),  32'(v.eDin));
   endtask

   localparam logic [5:0]  A = 6'b11_01_00;
   localparam logic [23:0] W = 24'h332211;

   initial begin
      rst_n = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

      // reset holds everything low even with requests present
      vecs.push_back(mk(0, 3'b111, 3'b000, 3'b000, A, W, 3'b000, 3'b000, 8'h00, 0, 0, 2'd0, 8'h00));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 8'h00, 0, 0, 2'd0, 8'h00));
      // all read, no lock: rotation 001,010,100 twice
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b010, 3'b001, 8'h10, 1, 0, 2'd1, 8'h22));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b100, 3'b010, 8'h11, 1, 0, 2'd3, 8'h33));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b100, 8'h13, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b010, 3'b001, 8'h10, 1, 0, 2'd1, 8'h22));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b100, 3'b010, 8'h11, 1, 0, 2'd3, 8'h33));
      // idle: RAM port quiet
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b100, 8'h13, 0, 0, 2'd0, 8'h00));
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b000, 8'h00, 0, 0, 2'd0, 8'h00));
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b000, 8'h00, 0, 0, 2'd0, 8'h00));
      // r1 writes A5 to addr 2, r2 reads it back
      vecs.push_back(mk(1, 3'b010, 3'b000, 3'b010, 6'h08, 24'h00A500, 3'b010, 3'b000, 8'h00, 1, 1, 2'd2, 8'hA5));
      vecs.push_back(mk(1, 3'b100, 3'b000, 3'b000, 6'h20, 24'h000000, 3'b100, 3'b000, 8'h00, 1, 0, 2'd2, 8'h00));
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 3'b100, 8'hA5, 0, 0, 2'd0, 8'h00));
      // r0 locks for 4 cycles, then releases and r1 is next
      vecs.push_back(mk(1, 3'b111, 3'b001, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b001, 3'b000, A, W, 3'b001, 3'b001, 8'h10, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b001, 3'b000, A, W, 3'b001, 3'b001, 8'h10, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b001, 3'b000, A, W, 3'b001, 3'b001, 8'h10, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b001, 8'h10, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b010, 3'b001, 8'h10, 1, 0, 2'd1, 8'h22));
      // r2 locks, then drops req: others stay blocked that cycle
      vecs.push_back(mk(1, 3'b111, 3'b100, 3'b000, A, W, 3'b100, 3'b010, 8'h11, 1, 0, 2'd3, 8'h33));
      vecs.push_back(mk(1, 3'b011, 3'b100, 3'b000, A, W, 3'b000, 3'b100, 8'h13, 0, 0, 2'd0, 8'h00));
      vecs.push_back(mk(1, 3'b011, 3'b000, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 1, 0, 2'd0, 8'h11));
      // only r2, then all: pointer wraps to 0
      vecs.push_back(mk(1, 3'b100, 3'b000, 3'b000, A, W, 3'b100, 3'b001, 8'h10, 1, 0, 2'd3, 8'h33));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b100, 8'h13, 1, 0, 2'd0, 8'h11));
      // read grant to r1, then reset pulse kills its rvalid
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b010, 3'b001, 8'h10, 1, 0, 2'd1, 8'h22));
      vecs.push_back(mk(0, 3'b111, 3'b000, 3'b000, A, W, 3'b000, 3'b000, 8'h00, 0, 0, 2'd0, 8'h00));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, A, W, 3'b001, 3'b000, 8'h00, 1, 0, 2'd0, 8'h11));
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, A, W, 3'b000, 3'b001, 8'h10, 0, 0, 2'd0, 8'h00));

      for (int n = 0; n < vecs.size(); n++) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[n]);
         @(negedge clk);
         checkRow(n, vecs[n]);
      end

      // hand sequence: reset in the middle of a lock drops ownership
      @(posedge clk); #1;
      rst_n = 1'b1; req = 3'b100; lock = 3'b100; we = '0; addr = A; wdata = W;
      @(negedge clk);
      checkOutput("lockseq take gnt", 32'(gnt), 32'(3'b100));
      @(posedge clk); #1;
      req = 3'b111;
      @(negedge clk);
      checkOutput("lockseq hold gnt", 32'(gnt), 32'(3'b100));
      checkOutput("lockseq hold rvalid", 32'(rvalid), 32'(3'b100));
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("lockseq reset gnt", 32'(gnt), 32'(3'b000));
      checkOutput("lockseq reset rvalid", 32'(rvalid), 32'(3'b000));
      @(posedge clk); #1;
      rst_n = 1'b1; lock = 3'b000;
      @(negedge clk);
      checkOutput("lockseq release gnt", 32'(gnt), 32'(3'b001));
      checkOutput("lockseq release rvalid", 32'(rvalid), 32'(3'b000));

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
      $finish;
   end

endmodule
